dptr_mc: RTL and testbench
==========================

Name: dptr_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle R-type datapath (DPTR).
- Executes a MIPS-subset program from an internal instruction memory, loaded through a write port.
- Uses a 4-state execute FSM, a 32-entry register file, an ALU and a retired-instruction counter.
- Sits stand-alone under a testbench or SoC controller. Adds start/halt control, a loadable program and debug visibility, none of which DPTR has.

Parameters:
- DATA_W, 32, register/ALU data width (>=8); immediates sign-extended or truncated to DATA_W.
- IMEM_DEPTH, 64, instruction memory words (power of 2); PC width PC_W = clog2(IMEM_DEPTH).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_we  in  1  instruction memory write enable (honoured only when not busy)
- imem_waddr  in  PC_W  instruction write address
- imem_wdata  in  32  instruction word
- start  in  1  begin execution from PC 0 (honoured in IDLE or HALTED)
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- halted  out  1  high in HALTED
- illegal  out  1  sticky: unsupported instruction encountered since last start
- pc  out  PC_W  current program counter
- instr_count  out  CNT_W  instructions retired since last start, saturating
- dbg_raddr  in  5  debug register-file read address
- dbg_rdata  out  DATA_W  combinational register-file read

Behaviour:
- Reset (rst=1 at edge): state IDLE; pc=0; all 32 registers=0; instr_count=0; illegal=0; busy=0; halted=0. Instruction memory contents are not cleared. Reset overrides everything, including mid-instruction.
- Instruction fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
- Supported instructions:
  - op=0x00 R-type: funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, NOR 0x27, SLT 0x2A (signed); result written to rd.
  - op=0x08 ADDI: rt = rs + sext(imm).
  - op=0x3F HALT.
- Any other op/funct is illegal: no register write, illegal<=1, retires normally, PC advances.
- Arithmetic is modulo 2^DATA_W; overflow is ignored.
- Register 0 reads 0 always; writes to it are discarded.
- FSM:
  - IDLE --start--> FETCH with pc<=0, instr_count<=0, illegal<=0.
  - FETCH: IR<=imem[pc]; ->DECODE.
  - DECODE: A<=R[rs], B<=R[rt]; if op=HALT ->HALTED (no retire), else ->EXEC.
  - EXEC: ALUOut<=f(A,B or sext(imm)); ->WB.
  - WB: register write; pc<=pc+1 mod IMEM_DEPTH (wraps to 0); instr_count+1, saturating at all-ones; ->FETCH.
  - HALTED --start--> FETCH with the same initialisation as IDLE. Registers retain values across restart.
- Latency: 4 cycles per instruction. busy rises the cycle after start is sampled. HALT reaches HALTED 2 cycles after its FETCH.
- Write-before-read: a register written in WB is visible to the next instruction's DECODE (no hazards; strictly sequential).
- dbg_rdata during a WB write to the same register shows the old value until the edge.
- imem_we while busy is ignored.
- imem_we and start in the same IDLE cycle: the write lands, and the FETCH one cycle later sees it.
- start while busy is ignored.

Decomposition:
- Package dptr_mc_pkg:
  - state enum {IDLE, FETCH, DECODE, EXEC, WB, HALTED}
  - opcode constants OP_RTYPE, OP_ADDI, OP_HALT
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT
  - ALU-op enum
- Sub-module alu_mc: combinational, parameter DATA_W; inputs a, b, alu_op; output y.
- Register file, instruction memory and FSM are inline in dptr_mc.

Test Plan:
- Reset mid-EXEC of an ADDI -> next cycle: state IDLE, pc=0, busy=0, destination register still 0, instr_count=0.
- Load ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SUB r4,r1,r2; HALT; pulse start -> halted after 4*4+2 cycles (plus the start cycle). Required values: r3=2, r4=8, instr_count=4, illegal=0.
- AND/OR/NOR/SLT with r1=0x0F0F, r2=0x00FF:
  - AND=0x000F
  - OR=0x0FFF
  - NOR=~0x0FFF
  - SLT r5,r2,r1 = 1
  - SLT with r1=-1 vs r2=1 -> 1 (signed)
- Write to r0 (ADDI r0,r0,7) then ADD r6,r0,r0 -> r6=0. Funct 0x3F in R-type -> illegal=1, no write, execution continues to HALT.
- IMEM_DEPTH=4, program with no HALT (4 ADDI r1,r1,1) -> pc wraps 3->0. After 8 retirements r1=8. Check PC_W=2 throughout.
- imem_we during busy leaves the program unchanged; start in HALTED reruns the program and resets instr_count/illegal; CNT_W=2 saturates at 3.

Source files
------------

// File: rtl/dptr_mc_pkg.sv
// Shared types and encodings for the dptr_mc multi-cycle datapath.
package dptr_mc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALTED
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT
  } alu_op_t;

  // Everything the later stages need to know about the latched instruction.
  typedef struct packed {
    alu_op_t    alu_op;
    logic       use_imm;
    logic       reg_we;
    logic [4:0] dest;
    logic       illegal;
  } dec_t;

  // Unsupported op/funct values produce no write and raise the illegal flag.
  // HALT is handled by the FSM and never reaches the write-back stage.
  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t d;
    d.alu_op  = ALU_ADD;
    d.use_imm = 1'b0;
    d.reg_we  = 1'b0;
    d.dest    = instr[15:11];
    d.illegal = 1'b0;
    case (instr[31:26])
      OP_RTYPE: begin
        d.reg_we = 1'b1;
        case (instr[5:0])
          F_ADD:   d.alu_op = ALU_ADD;
          F_SUB:   d.alu_op = ALU_SUB;
          F_AND:   d.alu_op = ALU_AND;
          F_OR:    d.alu_op = ALU_OR;
          F_NOR:   d.alu_op = ALU_NOR;
          F_SLT:   d.alu_op = ALU_SLT;
          default: begin
            d.reg_we  = 1'b0;
            d.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        d.use_imm = 1'b1;
        d.reg_we  = 1'b1;
        d.dest    = instr[20:16];
      end
      OP_HALT: d.reg_we = 1'b0;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dptr_mc_alu.sv
// alu_mc: combinational ALU for the multi-cycle datapath; wraps modulo 2^DATA_W.
module alu_mc
  import dptr_mc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           alu_op,
  output logic [DATA_W-1:0] y
);

  // Select the operation; SLT compares as two's-complement values.
  always_comb begin
    y = '0;
    case (alu_op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/dptr_mc.sv
// dptr_mc: multi-cycle MIPS-subset datapath with a loadable instruction
// memory, start/halt control, retired-instruction counter and a debug port.
module dptr_mc
  import dptr_mc_pkg::*;
#(
  parameter int  DATA_W     = 32,
  parameter int  IMEM_DEPTH = 64,
  parameter int  CNT_W      = 16,
  localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_waddr,
  input  logic [31:0]       imem_wdata,
  input  logic              start,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [PC_W-1:0]   pc,
  output logic [CNT_W-1:0]  instr_count,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] regs [32];
  logic [31:0]       ir;
  logic [5:0]        ir_op;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] imm_ext;
  dec_t              dec;

  assign ir_op     = ir[31:26];
  assign dec       = decode_instr(ir);
  assign imm_ext   = DATA_W'($signed(ir[15:0]));
  assign alu_b     = dec.use_imm ? imm_ext : b_reg;
  assign dbg_rdata = regs[dbg_raddr];

  alu_mc #(.DATA_W(DATA_W)) u_alu (
    .a      (a_reg),
    .b      (alu_b),
    .alu_op (dec.alu_op),
    .y      (alu_y)
  );

  // Program loading is only accepted while the core is not executing.
  always_ff @(posedge clk) begin
    if (imem_we && !busy)
      imem[imem_waddr] <= imem_wdata;
  end

  // Execute FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and status outputs; HALT leaves straight from DECODE without retiring.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    halted    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        busy      = 1'b1;
        state_nxt = (ir_op == OP_HALT) ? HALTED : EXEC;
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = WB;
      end
      WB: begin
        busy      = 1'b1;
        state_nxt = FETCH;
      end
      HALTED: begin
        halted = 1'b1;
        if (start) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pipeline-style holding registers, PC, retire counter and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      instr_count <= '0;
      illegal     <= 1'b0;
      ir          <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      alu_out     <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
            illegal     <= 1'b0;
          end
        end
        FETCH:  ir <= imem[pc];
        DECODE: begin
          a_reg <= regs[ir[25:21]];
          b_reg <= regs[ir[20:16]];
        end
        EXEC:   alu_out <= alu_y;
        WB: begin
          pc <= pc + PC_W'(1);
          if (instr_count != {CNT_W{1'b1}})
            instr_count <= instr_count + CNT_W'(1);
          if (dec.illegal)
            illegal <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Register file write port; register 0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (state == WB && dec.reg_we && dec.dest != 5'd0) begin
      regs[dec.dest] <= alu_out;
    end
  end

endmodule

// File: tb/tb_dptr_mc.sv
// Self-checking bench for dptr_mc: ISA-level reference model feeds a scoreboard,
// monitors compare on every halt (main core) and every retirement (small core).
module tb_dptr_mc;

  typedef struct packed {
    logic [31:0][31:0] regs;
    logic [15:0]       cnt;
    logic              ill;
    logic [5:0]        pc;
  } exp_t;

  typedef struct packed {
    logic [1:0] pc;
    logic [1:0] cnt;
    logic [7:0] r1;
  } sexp_t;

  localparam logic [31:0] HALT_W = {6'h3F, 26'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int monDone  = 0;
  int sMonDone = 0;

  exp_t        expQ[$];
  sexp_t       sExpQ[$];
  logic [31:0] mImem [64];
  logic [31:0] mRegs [32];
  logic [5:0]  fTab [6];
  bit          sActive = 1'b0;

  // main core: default parameters
  logic        rst, imemWe, start;
  logic [5:0]  imemWaddr;
  logic [31:0] imemWdata;
  logic        busy, halted, illegal;
  logic [5:0]  pc;
  logic [15:0] instrCount;
  logic [4:0]  dbgRaddr, stimAddr, monAddr;
  logic        monOwns = 1'b0;
  logic [31:0] dbgRdata;

  assign dbgRaddr = monOwns ? monAddr : stimAddr;

  // small core: 8-bit data, 4-word memory, 2-bit counter
  logic        sRst, sWe, sStart;
  logic [1:0]  sWaddr;
  logic [31:0] sWdata;
  logic        sBusy, sHalted, sIllegal;
  logic [1:0]  sPc;
  logic [1:0]  sCnt;
  logic [4:0]  sDbgAddr;
  logic [7:0]  sDbgData;

  assign sDbgAddr = 5'd1;

  dptr_mc #(.DATA_W(32), .IMEM_DEPTH(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .imem_we(imemWe), .imem_waddr(imemWaddr),
    .imem_wdata(imemWdata), .start(start), .busy(busy), .halted(halted),
    .illegal(illegal), .pc(pc), .instr_count(instrCount),
    .dbg_raddr(dbgRaddr), .dbg_rdata(dbgRdata)
  );

  dptr_mc #(.DATA_W(8), .IMEM_DEPTH(4), .CNT_W(2)) sdut (
    .clk(clk), .rst(sRst), .imem_we(sWe), .imem_waddr(sWaddr),
    .imem_wdata(sWdata), .start(sStart), .busy(sBusy), .halted(sHalted),
    .illegal(sIllegal), .pc(sPc), .instr_count(sCnt),
    .dbg_raddr(sDbgAddr), .dbg_rdata(sDbgData)
  );

  function automatic logic [31:0] rType(input int rd, input int rs, input int rt, input logic [5:0] f);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
  endfunction

  function automatic logic [31:0] addi(input int rt, input int rs, input int imm);
    return {6'h08, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] randInstr();
    int kind;
    logic [31:0] w;
    kind = int'($urandom_range(0, 9));
    if (kind < 6)
      w = rType(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), fTab[kind]);
    else if (kind < 9)
      w = addi(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 65535)));
    else if ($urandom_range(0, 1) == 0)
      w = rType(int'($urandom_range(0, 15)), 1, 2, 6'h00);
    else
      w = {6'h23, 26'($urandom)};
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // ISA-level interpreter: run the model memory from address 0 until HALT.
  task automatic runModel(output exp_t e, output int n);
    int p;
    bit ill, wr;
    logic [31:0] w, va, vb, res;
    logic [4:0] dest;
    p = 0; n = 0; ill = 1'b0;
    while (n < 1000) begin
      w = mImem[p];
      if (w[31:26] == 6'h3F) break;
      va = mRegs[w[25:21]];
      vb = mRegs[w[20:16]];
      wr = 1'b1; res = '0; dest = w[15:11];
      if (w[31:26] == 6'h00) begin
        case (w[5:0])
          6'h20: res = va + vb;
          6'h22: res = va - vb;
          6'h24: res = va & vb;
          6'h25: res = va | vb;
          6'h27: res = ~(va | vb);
          6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          default: begin wr = 1'b0; ill = 1'b1; end
        endcase
      end else if (w[31:26] == 6'h08) begin
        res  = va + {{16{w[15]}}, w[15:0]};
        dest = w[20:16];
      end else begin
        wr = 1'b0; ill = 1'b1;
      end
      if (wr && dest != 5'd0) mRegs[dest] = res;
      p = (p + 1) % 64;
      n++;
    end
    for (int i = 0; i < 32; i++) e.regs[i] = mRegs[i];
    e.cnt = 16'(n);
    e.ill = ill;
    e.pc  = 6'(p);
  endtask

  task automatic loadWord(input int addr, input logic [31:0] w);
    @(negedge clk);
    imemWe = 1'b1; imemWaddr = 6'(addr); imemWdata = w;
    mImem[addr] = w;
    @(negedge clk);
    imemWe = 1'b0;
  endtask

  task automatic resetAll();
    @(negedge clk);
    rst = 1'b1; sRst = 1'b1;
    @(negedge clk);
    rst = 1'b0; sRst = 1'b0;
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
  endtask

  // Load (optionally), start with word 0 written in the same cycle, predict, then time the run.
  task automatic applyStimulus(input logic [31:0] prog[$], input bit load, input bit busyPoke, input string tag);
    exp_t e;
    int n, cyc, target, g;
    if (load)
      for (int i = 1; i < prog.size(); i++) loadWord(i, prog[i]);
    @(negedge clk);
    start = 1'b1;
    if (load) begin
      imemWe = 1'b1; imemWaddr = 6'd0; imemWdata = prog[0];
      mImem[0] = prog[0];
    end
    runModel(e, n);
    expQ.push_back(e);
    target = monDone + 1;
    @(negedge clk);
    start = 1'b0; imemWe = 1'b0;
    checkOutput({tag, "_busyAfterStart"}, busy, 1);
    imemWaddr = 6'd1; imemWdata = 32'hF800_0000;
    cyc = 0;
    while (halted !== 1'b1 && cyc < 5000) begin
      imemWe = busyPoke && (cyc == 1);
      @(negedge clk);
      cyc++;
    end
    imemWe = 1'b0;
    checkOutput({tag, "_latency"}, cyc, 4 * n + 2);
    g = 0;
    while (monDone < target && g < 200) begin
      @(negedge clk);
      g++;
    end
    checkOutput({tag, "_monitorDone"}, monDone >= target, 1);
  endtask

  // Main-core monitor: on each rising halted, compare status and every register.
  initial begin : mainMonitor
    logic prevHalted;
    exp_t e;
    prevHalted = 1'b0;
    monAddr = '0;
    forever begin
      @(negedge clk);
      if (halted === 1'b1 && !prevHalted) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpectedHalt actual=1 required=0");
        end else begin
          e = expQ.pop_front();
          checkOutput("instrCount", instrCount, e.cnt);
          checkOutput("illegal", illegal, e.ill);
          checkOutput("haltPc", pc, e.pc);
          monOwns = 1'b1;
          for (int r = 0; r < 32; r++) begin
            monAddr = 5'(r);
            #1;
            checkOutput($sformatf("reg%0d", r), dbgRdata, e.regs[r]);
          end
          monOwns = 1'b0;
        end
        monDone++;
      end
      prevHalted = (halted === 1'b1);
    end
  end

  // Small-core monitor: every PC change is one retirement to score.
  initial begin : smallMonitor
    logic [1:0] prevPc;
    sexp_t se;
    prevPc = '0;
    forever begin
      @(negedge clk);
      if (sActive && sPc !== prevPc) begin
        if (sExpQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpectedRetire actual=%0h required=none", sPc);
        end else begin
          se = sExpQ.pop_front();
          checkOutput("smallPc", sPc, se.pc);
          checkOutput("smallCnt", sCnt, se.cnt);
          checkOutput("smallR1", sDbgData, se.r1);
        end
        sMonDone++;
      end
      prevPc = sPc;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] prog[$];
    logic [31:0] empty[$];
    sexp_t se;
    int g;
    rst = 1'b0; imemWe = 1'b0; imemWaddr = '0; imemWdata = '0; start = 1'b0; stimAddr = '0;
    sRst = 1'b0; sWe = 1'b0; sWaddr = '0; sWdata = '0; sStart = 1'b0;
    fTab[0] = 6'h20; fTab[1] = 6'h22; fTab[2] = 6'h24;
    fTab[3] = 6'h25; fTab[4] = 6'h27; fTab[5] = 6'h2A;

    resetAll();
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstHalted", halted, 0);
    checkOutput("rstPc", pc, 0);
    checkOutput("rstCnt", instrCount, 0);
    checkOutput("rstIllegal", illegal, 0);

    // reset in the middle of an ADDI's EXEC cycle
    loadWord(1, HALT_W);
    @(negedge clk);
    start = 1'b1; imemWe = 1'b1; imemWaddr = 6'd0; imemWdata = addi(1, 0, 5);
    mImem[0] = addi(1, 0, 5);
    @(negedge clk);
    start = 1'b0; imemWe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midExecBusy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stimAddr = 5'd1;
    #1;
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstPc", pc, 0);
    checkOutput("midRstCnt", instrCount, 0);
    checkOutput("midRstR1", dbgRdata, 0);

    // basic arithmetic program
    prog.delete();
    prog.push_back(addi(1, 0, 5));
    prog.push_back(addi(2, 0, -3));
    prog.push_back(rType(3, 1, 2, 6'h20));
    prog.push_back(rType(4, 1, 2, 6'h22));
    prog.push_back(HALT_W);
    applyStimulus(prog, 1'b1, 1'b0, "arith");

    // logic ops and signed compare
    prog.delete();
    prog.push_back(addi(1, 0, 16'h0F0F));
    prog.push_back(addi(2, 0, 16'h00FF));
    prog.push_back(rType(3, 1, 2, 6'h24));
    prog.push_back(rType(4, 1, 2, 6'h25));
    prog.push_back(rType(7, 1, 2, 6'h27));
    prog.push_back(rType(5, 2, 1, 6'h2A));
    prog.push_back(addi(1, 0, -1));
    prog.push_back(addi(2, 0, 1));
    prog.push_back(rType(8, 1, 2, 6'h2A));
    prog.push_back(rType(9, 2, 1, 6'h2A));
    prog.push_back(HALT_W);
    applyStimulus(prog, 1'b1, 1'b0, "logic");

    // r0 writes discarded, illegal encodings retire without writing
    prog.delete();
    prog.push_back(addi(0, 0, 7));
    prog.push_back(rType(6, 0, 0, 6'h20));
    prog.push_back(rType(10, 1, 2, 6'h3F));
    prog.push_back(32'h8C00_0000);
    prog.push_back(addi(11, 0, 9));
    prog.push_back(HALT_W);
    applyStimulus(prog, 1'b1, 1'b0, "illegal");

    // memory write during busy is ignored; restart from HALTED reruns
    prog.delete();
    prog.push_back(addi(12, 12, 1));
    prog.push_back(addi(12, 12, 1));
    prog.push_back(addi(12, 12, 1));
    prog.push_back(HALT_W);
    applyStimulus(prog, 1'b1, 1'b1, "busyWrite");
    applyStimulus(empty, 1'b0, 1'b0, "rerun");

    // randomized programs
    for (int k = 0; k < 5; k++) begin
      prog.delete();
      for (int j = 0; j < 12; j++) prog.push_back(randInstr());
      prog.push_back(HALT_W);
      applyStimulus(prog, 1'b1, 1'b0, $sformatf("rand%0d", k));
    end

    // reset clears the register file and status
    resetAll();
    checkOutput("finalRstHalted", halted, 0);
    checkOutput("finalRstCnt", instrCount, 0);
    for (int r = 0; r < 32; r++) begin
      stimAddr = 5'(r);
      #1;
      checkOutput($sformatf("finalRstReg%0d", r), dbgRdata, 0);
    end

    // small core: PC wrap with no HALT and saturating 2-bit counter
    sActive = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sWe = 1'b1; sWaddr = 2'(i); sWdata = addi(1, 1, 1);
      @(negedge clk);
      sWe = 1'b0;
    end
    for (int i = 1; i <= 10; i++) begin
      se.pc  = 2'(i % 4);
      se.cnt = (i > 3) ? 2'd3 : 2'(i);
      se.r1  = 8'(i);
      sExpQ.push_back(se);
    end
    @(negedge clk);
    sStart = 1'b1;
    @(negedge clk);
    sStart = 1'b0;
    checkOutput("smallBusyAfterStart", sBusy, 1);
    g = 0;
    while (sMonDone < 10 && g < 200) begin
      @(negedge clk);
      g++;
    end
    checkOutput("smallRetired", sMonDone, 10);
    checkOutput("smallStillRunning", sBusy, 1);
    checkOutput("smallNeverHalted", sHalted, 0);
    sActive = 1'b0;
    @(negedge clk);
    sRst = 1'b1;
    @(negedge clk);
    sRst = 1'b0;
    #1;
    checkOutput("smallRstPc", sPc, 0);
    checkOutput("smallRstCnt", sCnt, 0);
    checkOutput("smallRstBusy", sBusy, 0);
    checkOutput("smallRstR1", sDbgData, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
